// File: rtl/sipo_capture_pkg.sv
// Shared types and defaults for the serial-to-parallel capture controller.
package sipo_capture_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } cap_state_t;

  localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/sipo_shift_en.sv
// Enabled left-shift register; the serial bit enters the LSB so the first
// bit received ends up in the MSB. Exposes its next value for same-edge capture.
module sipo_shift_en
  import sipo_capture_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] data_next
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next shifter contents: shift in din only while enabled.
  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = {data_q[WIDTH-2:0], din};
    end else begin
      data_d = data_q;
    end
  end

  // Shifter storage with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= {WIDTH{1'b0}};
    end else begin
      data_q <= data_d;
    end
  end

  assign data_next = data_d;

endmodule

// File: rtl/sipo_capture_ctrl.sv
// Sequences a SIPO shifter to capture WIDTH-bit words and hands them to a
// consumer over valid/ready, flagging words dropped under back-pressure.
module sipo_capture_ctrl
  import sipo_capture_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             din,
  input  logic             clr_err,
  input  logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] word_out,
  output logic             valid,
  output logic             overrun
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  cap_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic             shift_en_s;
  logic             done_s;
  logic             xfer_s;
  logic             load_s;
  logic             drop_s;
  logic [WIDTH-1:0] shift_next_s;

  assign shift_en_s = (state_q == SHIFT);

  sipo_shift_en #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .en       (shift_en_s),
    .din      (din),
    .data_next(shift_next_s)
  );

  // Capture FSM: next state, bit counter and final-bit detection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST_BIT) begin
          // Final bit; a start seen here chains straight into the next word.
          done_s  = 1'b1;
          cnt_d   = {CW{1'b0}};
          state_d = start ? SHIFT : IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // Output register handshake: load, hold, drop and sticky overrun.
  always_comb begin
    xfer_s  = valid_q & ready;
    load_s  = done_s & (~valid_q | ready);
    drop_s  = done_s & valid_q & ~ready;
    word_d  = word_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    busy_d  = (state_d == SHIFT);
    if (load_s) begin
      word_d  = shift_next_s;
      valid_d = 1'b1;
    end else if (xfer_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    // Setting wins over clearing when both happen on one edge.
    if (drop_s) begin
      ovr_d = 1'b1;
    end else if (clr_err) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      busy_q  <= 1'b0;
      word_q  <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign busy     = busy_q;
  assign word_out = word_q;
  assign valid    = valid_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_sipo_capture_ctrl.sv
// Self-checking bench for sipo_capture_ctrl: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_sipo_capture_ctrl;
  import sipo_capture_pkg::*;

  localparam int W = DEF_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         din;
  logic         clr_err;
  logic         ready;
  logic         busy;
  logic [W-1:0] word_out;
  logic         valid;
  logic         overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int cycnt   = 0;

  // Reference model state: capture in progress, bits received so far, output slot.
  bit           m_cap;
  int           m_bits[$];
  logic         m_valid;
  logic [W-1:0] m_word;
  logic         m_ovr;

  sipo_capture_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .din     (din),
    .clr_err (clr_err),
    .ready   (ready),
    .busy    (busy),
    .word_out(word_out),
    .valid   (valid),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_cap = 1'b0;
    m_bits.delete();
    m_valid = 1'b0;
    m_word  = '0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic d, input logic r, input logic c);
    bit   done;
    bit   old_valid;
    bit   drop;
    int   nw;
    done = 1'b0;
    drop = 1'b0;
    nw = 0;
    old_valid = m_valid;
    if (m_cap) begin
      m_bits.push_back(int'(d));
      if (m_bits.size() == W) begin
        foreach (m_bits[i]) nw = nw * 2 + m_bits[i];
        m_bits.delete();
        done  = 1'b1;
        m_cap = s;
      end
    end else if (s) begin
      m_cap = 1'b1;
    end
    if (old_valid && r) m_valid = 1'b0;
    if (done) begin
      if (!old_valid || r) begin
        m_word  = nw[W-1:0];
        m_valid = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
    if (drop) m_ovr = 1'b1;
    else if (c) m_ovr = 1'b0;
  endtask

  // One clock: drive inputs just after an edge, step the model at the next edge.
  task automatic cyc(input logic s, input logic d, input logic r, input logic c);
    start = s; din = d; ready = r; clr_err = c;
    @(posedge clk);
    model_step(s, d, r, c);
    cycnt++;
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] p, input logic r, input logic start_last);
    for (int i = 0; i < W; i++) cyc((i == W - 1) ? start_last : 1'b0, p[W-1-i], r, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; din = 1'b0; clr_err = 1'b0; ready = 1'b0;
    #3 rst = 1'b0;
    #1;
    model_reset();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_tests++; if (word_out !== 4'b0000) begin n_fail++; $display("FAIL reset_word: got %b want 0000", word_out); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    @(posedge clk);
    #1 rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    n_tests++; if (busy !== 1'b0 || valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got busy=%b valid=%b want 0 0", busy, valid); end
  endtask

  task automatic test_basic();
    logic [W-1:0] p;
    int bc;
    p = 4'b1011;
    bc = 0;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    if (busy) bc++;
    for (int i = 0; i < W; i++) begin
      cyc(1'b0, p[W-1-i], 1'b1, 1'b0);
      if (busy) bc++;
      if (i == W - 2) begin
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", valid); end
      end
    end
    n_tests++; if (bc !== 4) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 4", bc); end
    n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", valid); end
    n_tests++; if (word_out !== 4'b1011) begin n_fail++; $display("FAIL basic_word: got %b want 1011", word_out); end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_consumed: got %b want 0", valid); end
  endtask

  task automatic test_backpressure();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(4'b0110, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (valid !== 1'b1 || word_out !== 4'b0110) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got valid=%b word=%b want 1 0110", i, valid, word_out);
      end
      cyc(1'b0, 1'($urandom), 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b want 0", valid); end
  endtask

  task automatic test_overrun();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(4'b1100, 1'b0, 1'b0);
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first: got %b want 0", overrun); end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(4'b0011, 1'b0, 1'b0);
    n_tests++; if (word_out !== 4'b1100) begin n_fail++; $display("FAIL ovr_word_kept: got %b want 1100", word_out); end
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", overrun); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    n_tests++; if (valid !== 1'b1 || word_out !== 4'b1100) begin n_fail++; $display("FAIL ovr_clear_hold: got valid=%b word=%b want 1 1100", valid, word_out); end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] p2;
    int t1;
    int t2;
    bit dropped;
    p2 = 4'b0111;
    t2 = 0;
    dropped = 1'b0;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    send_word(4'b1001, 1'b1, 1'b1);
    t1 = cycnt;
    if (!busy) dropped = 1'b1;
    n_tests++; if (valid !== 1'b1 || word_out !== 4'b1001) begin n_fail++; $display("FAIL b2b_first: got valid=%b word=%b want 1 1001", valid, word_out); end
    for (int i = 0; i < W; i++) begin
      cyc(1'b0, p2[W-1-i], 1'b1, 1'b0);
      if (i < W - 1 && !busy) dropped = 1'b1;
      if (valid && t2 == 0) t2 = cycnt;
    end
    n_tests++; if (dropped) begin n_fail++; $display("FAIL b2b_busy: got busy drop want continuous"); end
    n_tests++; if (word_out !== 4'b0111) begin n_fail++; $display("FAIL b2b_second: got %b want 0111", word_out); end
    n_tests++; if (t2 - t1 !== 4) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 4", t2 - t1); end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_start_mid();
    logic [W-1:0] p;
    p = 4'b1010;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < W; i++) cyc((i == 1) ? 1'b1 : 1'b0, p[W-1-i], 1'b1, 1'b0);
    n_tests++; if (word_out !== 4'b1010 || valid !== 1'b1) begin n_fail++; $display("FAIL mid_word: got valid=%b word=%b want 1 1010", valid, word_out); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle: got busy=%b want 0", busy); end
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    n_tests++; if (busy !== 1'b0 || valid !== 1'b0) begin n_fail++; $display("FAIL mid_after: got busy=%b valid=%b want 0 0", busy, valid); end
  endtask

  task automatic test_async_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(4'b1110, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(4'b1111, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    n_tests++; if (busy !== 1'b1 || overrun !== 1'b1) begin n_fail++; $display("FAIL ar_pre: got busy=%b overrun=%b want 1 1", busy, overrun); end
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (busy !== 1'b0 || valid !== 1'b0 || word_out !== 4'b0000 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL ar_immediate: got busy=%b valid=%b word=%b ovr=%b want all 0", busy, valid, word_out, overrun);
    end
    #2 rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    send_word(4'b0101, 1'b1, 1'b0);
    n_tests++; if (word_out !== 4'b0101 || valid !== 1'b1) begin n_fail++; $display("FAIL ar_fresh: got valid=%b word=%b want 1 0101", valid, word_out); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ar_fresh_ovr: got %b want 0", overrun); end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic s, d, r, c;
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 3) == 0);
      d = 1'($urandom);
      r = ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 15) == 0);
      cyc(s, d, r, c);
      n_tests++;
      if (busy !== m_cap || valid !== m_valid || word_out !== m_word || overrun !== m_ovr) begin
        n_fail++;
        $display("FAIL rand[%0d]: got busy=%b valid=%b word=%b ovr=%b want %b %b %b %b",
                 i, busy, valid, word_out, overrun, m_cap, m_valid, m_word, m_ovr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_start_mid();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_capture_ctrl.md
Name: sipo_capture_ctrl

Overview:
Controller that sequences a serial-in/parallel-out shift register to capture fixed-width words from a serial line. It starts a capture on command and counts exactly WIDTH bits into the shifter. It then hands the completed word to a downstream consumer over a valid/ready handshake. It sits between the serial input pin logic and any parallel consumer, and flags words lost to back-pressure.

Parameters:
WIDTH, 4, number of serial bits per captured word (legal range 2..32).

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  asynchronous reset, active-low (0 = reset asserted).
start  input  1  capture request; sampled each cycle.
din  input  1  serial data bit.
clr_err  input  1  clears the sticky overrun flag.
ready  input  1  downstream accepts word_out when high together with valid.
busy  output  1  high while a capture is in progress (state SHIFT).
word_out  output  WIDTH  captured word; stable while valid=1.
valid  output  1  word_out holds an unconsumed word.
overrun  output  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, bit counter=0, shifter=0, word_out=0, valid=0, overrun=0, busy=0. Reset mid-capture discards the partial word.
- Shifter: shifts left with din entering the LSB, so the first bit received ends in the MSB. It shifts only when shift_en=1 (shift_en = state==SHIFT).
- States:
  - IDLE: busy=0. If start=1, go to SHIFT and set counter=0.
  - SHIFT: busy=1. Each cycle, sample din into the shifter and increment the counter.
    - When counter==WIDTH-1, that cycle is the final bit. The completed word ({shifter[WIDTH-2:0], din}) is offered to the output register. Next state is SHIFT with counter=0 if start=1 in this cycle (back-to-back capture), else IDLE.
    - start in any other SHIFT cycle is ignored.
- Latency: start high at edge t. Bits are sampled at edges t+1..t+WIDTH. valid=1 from edge t+WIDTH onward, i.e. visible in the cycle after the final bit.
- Output register and handshake:
  - A transfer occurs on an edge where valid=1 and ready=1. valid then clears unless a new word loads on the same edge.
  - A completed word loads if valid=0, or valid=1 and ready=1 in the same cycle. In that case word_out is updated and valid=1.
  - If valid=1 and ready=0 when a word completes: the new word is dropped, word_out keeps the old word, and overrun is set to 1.
  - word_out and valid never change while valid=1 and ready=0, except on reset.
- Overrun is sticky. clr_err=1 clears it. If clr_err=1 and a new overrun occur on the same edge, set wins (overrun=1).
- Counter width: $clog2(WIDTH). The counter never exceeds WIDTH-1.

Decomposition:
- Package sipo_capture_pkg holds:
  - typedef enum logic {IDLE, SHIFT} cap_state_t;
  - localparam DEF_WIDTH = 4.
- Sub-module sipo_shift_en: parameterised WIDTH shift register with enable, the same asynchronous active-low reset, left shift with din into the LSB. The controller instantiates it and drives its enable.

Test Plan:
- Basic capture (WIDTH=4, ready=1): start pulse, then din=1,0,1,1 on the next 4 cycles -> valid=1 one cycle after the 4th bit, word_out=4'b1011, busy high exactly 4 cycles.
- Back-pressure hold: ready=0, capture 0110 -> valid=1, word_out=4'b0110 held stable for 10 cycles. Raise ready for 1 cycle -> valid=0 on the next edge.
- Overrun: ready=0, capture 1100, then capture 0011 -> word_out stays 4'b1100 and overrun=1. Pulse clr_err -> overrun=0, while valid stays 1.
- Back-to-back: start held high during the final bit of 1001, then din=0,1,1,1, ready=1 -> two words 4'b1001 and 4'b0111, busy never drops, second valid 4 cycles after the first.
- Start mid-capture: extra start pulse at bit 2 of 1010 -> ignored, word_out=4'b1010, state returns to IDLE.
- Async reset mid-capture: rst=0 after 2 bits, between clock edges -> outputs immediately 0, busy=0. After release, a fresh capture of 0101 yields 4'b0101 with no residue.
